// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Hits are answered combinationally; a miss refills the whole line in word order.
module icache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] f_in_pc,
  input  logic              f_in_req,
  input  logic              f_in_inv_all,
  output logic [31:0]       ic_out_instr,
  output logic              icache_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  // Both NUM_LINES and LINE_WORDS are assumed to be powers of two and at least 2.
  localparam int OB    = $clog2(LINE_WORDS);
  localparam int IB    = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 2 - OB - IB;

  typedef enum logic [0:0] {IDLE, REFILL} state_t;

  state_t           state, state_nx;
  logic [OB-1:0]    cnt;
  logic [IB-1:0]    ref_idx;
  logic [TAG_W-1:0] ref_tag;
  logic             kill;
  logic             start;
  logic             ack_fire;
  logic             last_word;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES*LINE_WORDS];

  logic [OB-1:0]    pc_off;
  logic [IB-1:0]    pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_lsbs;

  assign pc_off         = f_in_pc[2+OB-1:2];
  assign pc_idx         = f_in_pc[2+OB+IB-1:2+OB];
  assign pc_tag         = f_in_pc[ADDR_W-1:2+OB+IB];
  assign unused_pc_lsbs = ^f_in_pc[1:0];

  assign icache_hit   = ~rst & (state == IDLE) & f_in_req & valid[pc_idx] &
                        (tags[pc_idx] == pc_tag);
  assign ic_out_instr = data[{pc_idx, pc_off}];
  assign ack_fire     = (state == REFILL) & mem_ack;
  assign last_word    = (cnt == OB'(LINE_WORDS - 1));
  assign mem_addr     = {ref_tag, ref_idx, cnt, 2'b00};

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    mem_req  = 1'b0;
    case (state)
      IDLE: begin
        // fence.i in the same cycle as a miss suppresses the refill
        if (f_in_req && !icache_hit && !f_in_inv_all) begin
          state_nx = REFILL;
          start    = 1'b1;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (ack_fire && last_word) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ref_idx <= '0;
      ref_tag <= '0;
      kill    <= 1'b0;
      valid   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        ref_idx <= pc_idx;
        ref_tag <= pc_tag;
        cnt     <= '0;
      end else if (ack_fire) begin
        cnt <= cnt + OB'(1);
      end
      if (state == IDLE)     kill <= 1'b0;
      else if (f_in_inv_all) kill <= 1'b1;
      // invalidate-all wins over the valid write of a completing fill
      if (f_in_inv_all)              valid          <= '0;
      else if (ack_fire && last_word) valid[ref_idx] <= ~kill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ack_fire) begin
      data[{ref_idx, cnt}] <= mem_rdata;
      if (last_word) tags[ref_idx] <= ref_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a line-level cache model.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_in_pc;
  logic        f_in_req;
  logic        f_in_inv_all;
  logic [31:0] ic_out_instr;
  logic        icache_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  icache_ctrl #(.ADDR_W(32), .NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .f_in_pc(f_in_pc), .f_in_req(f_in_req),
    .f_in_inv_all(f_in_inv_all), .ic_out_instr(ic_out_instr),
    .icache_hit(icache_hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: memory is a fixed function of address; the cache is a valid/tag map
  // per index, and a pending refill is the queue of word addresses still owed.
  logic [31:0] q[$];
  bit          m_valid [16];
  int          m_tag   [16];
  bit          m_kill;
  int          r_idx, r_tag;

  logic        obs_hit, obs_req;
  logic [31:0] obs_addr, obs_instr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_kill = 1'b0;
  endtask

  // One clock cycle: drive, compare combinational outputs, then advance model.
  task automatic step(input bit r, input bit rq, input logic [31:0] p,
                      input bit inv, input bit ak);
    int idx, tg;
    bit exp_hit, busy;
    rst = r; f_in_req = rq; f_in_pc = p; f_in_inv_all = inv; mem_ack = ak;
    mem_rdata = (q.size() != 0) ? memfn(q[0]) : $urandom;
    #3;
    obs_hit = icache_hit; obs_req = mem_req; obs_addr = mem_addr; obs_instr = ic_out_instr;
    idx  = int'((p >> 4) & 32'hF);
    tg   = int'(p >> 8);
    busy = (q.size() != 0);
    exp_hit = !r && !busy && rq && m_valid[idx] && (m_tag[idx] == tg);
    check("hit", {31'd0, obs_hit}, {31'd0, exp_hit});
    if (exp_hit && obs_hit) check("instr", obs_instr, memfn(p & 32'hFFFF_FFFC));
    check("mem_req", {31'd0, obs_req}, {31'd0, busy});
    if (busy && obs_req) check("mem_addr", obs_addr, q[0]);
    @(posedge clk); #1;
    if (r) begin
      model_reset();
    end else begin
      if (busy) begin
        if (ak) begin
          void'(q.pop_front());
          if (q.size() == 0 && !m_kill) begin
            m_valid[r_idx] = 1'b1;
            m_tag[r_idx]   = r_tag;
          end
        end
        if (inv) m_kill = 1'b1;
      end else begin
        m_kill = 1'b0;
        if (rq && !exp_hit && !inv) begin
          for (int k = 0; k < 4; k++) q.push_back((p & 32'hFFFF_FFF0) + 32'(4 * k));
          r_idx = idx;
          r_tag = tg;
        end
      end
      if (inv) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end
  endtask

  task automatic refill_ack_each(input logic [31:0] base, input logic [31:0] pc_drv);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, pc_drv, 0, 1);
      check("refill_addr", obs_addr, base + 32'(4 * k));
    end
  endtask

  initial begin
    rst = 1'b1; f_in_req = 1'b0; f_in_pc = '0; f_in_inv_all = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    for (int i = 0; i < 16; i++) m_tag[i] = -1;
    @(posedge clk); #1;

    // T1: reset state, then cold miss at 0x40
    step(1, 1, 32'h40, 0, 1);
    check("rst_hit", {31'd0, obs_hit}, 32'd0);
    check("rst_req", {31'd0, obs_req}, 32'd0);
    check("rst_addr", obs_addr, 32'h0);
    step(0, 1, 32'h40, 0, 0);
    check("t1_miss", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h40, 32'h40);
    step(0, 1, 32'h40, 0, 0);
    check("t1_hit_lat", {31'd0, obs_hit}, 32'd1);
    check("t1_instr", obs_instr, memfn(32'h40));

    // T2: another word of the same line
    step(0, 1, 32'h48, 0, 0);
    check("t2_hit", {31'd0, obs_hit}, 32'd1);
    check("t2_instr", obs_instr, memfn(32'h48));
    check("t2_req", {31'd0, obs_req}, 32'd0);

    // T3: conflicting line 0x140 evicts 0x40
    step(0, 1, 32'h140, 0, 0);
    check("t3_miss", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h140, 32'h140);
    step(0, 1, 32'h14C, 0, 0);
    check("t3_hit", {31'd0, obs_hit}, 32'd1);
    step(0, 1, 32'h40, 0, 0);
    check("t3_evict", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h40, 32'h40);

    // T4: acks with 3-cycle gaps, request and address must hold
    step(0, 1, 32'h84, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 32'h84, 0, 0);
        check("t4_req_hold", {31'd0, obs_req}, 32'd1);
        check("t4_addr_hold", obs_addr, 32'h80 + 32'(4 * k));
      end
      step(0, 1, 32'h84, 0, 1);
    end
    step(0, 1, 32'h84, 0, 0);
    check("t4_hit", {31'd0, obs_hit}, 32'd1);
    check("t4_instr", obs_instr, memfn(32'h84));

    // T5: fence.i during the 2nd refill word
    step(0, 1, 32'h200, 0, 0);
    step(0, 1, 32'h200, 0, 1);
    step(0, 1, 32'h200, 1, 1);
    step(0, 1, 32'h200, 0, 1);
    step(0, 0, 32'h200, 0, 1);
    check("t5_done_req", {31'd0, obs_req}, 32'd1);
    step(0, 1, 32'h40, 1, 0);
    check("t5_inv_miss", {31'd0, obs_hit}, 32'd0);
    step(0, 1, 32'h48, 0, 0);
    check("t5_t2_inv", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h40, 32'h40);
    step(0, 1, 32'h200, 0, 0);
    check("t5_killed", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h200, 32'h200);

    // T6: reset mid-refill, then PC change during a refill
    step(0, 1, 32'h300, 0, 0);
    step(0, 1, 32'h300, 0, 1);
    step(1, 1, 32'h300, 0, 1);
    step(0, 0, 32'h300, 0, 1);
    check("t6_rst_req", {31'd0, obs_req}, 32'd0);
    step(0, 1, 32'h84, 0, 0);
    check("t6_rst_inv", {31'd0, obs_hit}, 32'd0);
    refill_ack_each(32'h80, 32'h500);
    step(0, 1, 32'h500, 0, 0);
    check("t6_newpc_miss", {31'd0, obs_hit}, 32'd0);
    step(0, 1, 32'h500, 0, 1);
    check("t6_newpc_addr", obs_addr, 32'h500);
    for (int k = 1; k < 4; k++) step(0, 1, 32'h500, 0, 1);
    step(0, 1, 32'h508, 0, 0);
    check("t6_newpc_hit", {31'd0, obs_hit}, 32'd1);
    step(0, 1, 32'h84, 0, 0);
    check("t6_old_done", {31'd0, obs_hit}, 32'd1);

    // Randomized traffic over a small address pool to mix hits and conflicts
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] p;
      p = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 5)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, p,
           $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
